// File: rtl/io_hub_mc.sv
// io_hub_mc: bridges the CPU inp/out request-acknowledge handshakes to N_CH
// device channels. Each channel has an RX FIFO (device to CPU) and a TX FIFO
// (CPU to device).
// Optional build macro IO_TIMEOUT_EN adds a stall timeout. A timed-out transfer
// is acknowledged with err=1.
module io_hub_mc #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   inp_req,
  input  logic [CH_W-1:0]        inp_ch,
  output logic [DATA_W-1:0]      inp_data,
  output logic                   inp_ack,
  input  logic                   out_req,
  input  logic [CH_W-1:0]        out_ch,
  input  logic [DATA_W-1:0]      out_data,
  output logic                   out_ack,
  output logic                   err,
  input  logic [N_CH-1:0]        dev_in_valid,
  input  logic [N_CH*DATA_W-1:0] dev_in_data,
  output logic [N_CH-1:0]        dev_in_ready,
  output logic [N_CH-1:0]        dev_out_valid,
  output logic [N_CH*DATA_W-1:0] dev_out_data,
  input  logic [N_CH-1:0]        dev_out_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_ACK  = 3'd2,
    WR_WAIT = 3'd3,
    WR_ACK  = 3'd4,
    RELEASE = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic [DATA_W-1:0]   inp_data_q, inp_data_d;
  logic                inp_ack_q, inp_ack_d;
  logic                out_ack_q, out_ack_d;
  logic                err_q, err_d;

  logic [N_CH-1:0]     rx_full, rx_empty, tx_full, tx_empty;
  logic [DATA_W-1:0]   rx_head [N_CH];
  logic [N_CH-1:0]     rx_pop_c, tx_push_c;

  logic                sel_rx_empty, sel_tx_full;
  logic [DATA_W-1:0]   sel_rx_head;
  logic [N_CH-1:0]     ch_hot;

`ifdef IO_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     tmo_q, tmo_d;
  logic [TO_W-1:0]     tmo_inc;
  logic                tmo_expired;
  assign tmo_inc     = tmo_q + TO_W'(1);
  assign tmo_expired = (tmo_inc == TO_W'(TIMEOUT));
`endif

  // Per-channel RX and TX FIFOs
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [PTR_W-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic              rx_push, rx_pop, tx_push, tx_pop;

    assign rx_full[c]  = (rx_cnt_q == CNT_W'(FIFO_DEPTH));
    assign rx_empty[c] = (rx_cnt_q == '0);
    assign tx_full[c]  = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
    assign tx_empty[c] = (tx_cnt_q == '0);

    // Ready looks only at the registered count, so a full FIFO never takes a push
    assign rx_push = dev_in_valid[c] & ~rx_full[c];
    assign rx_pop  = rx_pop_c[c];
    assign tx_push = tx_push_c[c];
    assign tx_pop  = dev_out_ready[c] & ~tx_empty[c];

    assign rx_head[c]                        = rx_mem_q[rx_rp_q];
    assign dev_in_ready[c]                   = ~rx_full[c];
    assign dev_out_valid[c]                  = ~tx_empty[c];
    assign dev_out_data[c*DATA_W +: DATA_W]  = tx_mem_q[tx_rp_q];

    // Pointer and count next-state; pointers wrap naturally at FIFO_DEPTH
    always_comb begin
      rx_wp_d  = rx_push ? rx_wp_q + PTR_W'(1) : rx_wp_q;
      rx_rp_d  = rx_pop  ? rx_rp_q + PTR_W'(1) : rx_rp_q;
      rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
      tx_wp_d  = tx_push ? tx_wp_q + PTR_W'(1) : tx_wp_q;
      tx_rp_d  = tx_pop  ? tx_rp_q + PTR_W'(1) : tx_rp_q;
      tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
      if (rst_b) begin
        rx_wp_q  <= '0;
        rx_rp_q  <= '0;
        rx_cnt_q <= '0;
        tx_wp_q  <= '0;
        tx_rp_q  <= '0;
        tx_cnt_q <= '0;
      end else begin
        rx_wp_q  <= rx_wp_d;
        rx_rp_q  <= rx_rp_d;
        rx_cnt_q <= rx_cnt_d;
        tx_wp_q  <= tx_wp_d;
        tx_rp_q  <= tx_rp_d;
        tx_cnt_q <= tx_cnt_d;
      end
    end

    // Storage arrays; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= dev_in_data[c*DATA_W +: DATA_W];
      if (tx_push) tx_mem_q[tx_wp_q] <= wdata_q;
    end
  end

  // Status of the latched channel; out-of-range channels look empty and full
  always_comb begin
    sel_rx_empty = 1'b1;
    sel_tx_full  = 1'b1;
    sel_rx_head  = '0;
    ch_hot       = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (ch_q == CH_W'(c)) begin
        sel_rx_empty = rx_empty[c];
        sel_tx_full  = tx_full[c];
        sel_rx_head  = rx_head[c];
        ch_hot[c]    = 1'b1;
      end
    end
  end

  // Transfer FSM next-state and outputs
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    inp_data_d = inp_data_q;
    inp_ack_d  = 1'b0;
    out_ack_d  = 1'b0;
    err_d      = 1'b0;
    rx_pop_c   = '0;
    tx_push_c  = '0;
`ifdef IO_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (inp_req) begin
          ch_d    = inp_ch;
          rd_d    = 1'b1;
          state_d = RD_WAIT;
`ifdef IO_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else if (out_req) begin
          ch_d    = out_ch;
          wdata_d = out_data;
          rd_d    = 1'b0;
          state_d = WR_WAIT;
`ifdef IO_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      RD_WAIT: begin
        if (!sel_rx_empty) begin
          rx_pop_c   = ch_hot;
          inp_data_d = sel_rx_head;
          inp_ack_d  = 1'b1;
          state_d    = RD_ACK;
        end
`ifdef IO_TIMEOUT_EN
        else if (tmo_expired) begin
          inp_data_d = '0;
          inp_ack_d  = 1'b1;
          err_d      = 1'b1;
          state_d    = RD_ACK;
        end else begin
          tmo_d = tmo_inc;
        end
`endif
      end
      RD_ACK:  state_d = RELEASE;
      WR_WAIT: begin
        if (!sel_tx_full) begin
          tx_push_c = ch_hot;
          out_ack_d = 1'b1;
          state_d   = WR_ACK;
        end
`ifdef IO_TIMEOUT_EN
        else if (tmo_expired) begin
          out_ack_d = 1'b1;
          err_d     = 1'b1;
          state_d   = WR_ACK;
        end else begin
          tmo_d = tmo_inc;
        end
`endif
      end
      WR_ACK:  state_d = RELEASE;
      RELEASE: begin
        if (rd_q ? !inp_req : !out_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer FSM registers
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      inp_data_q <= '0;
      inp_ack_q  <= 1'b0;
      out_ack_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      inp_data_q <= inp_data_d;
      inp_ack_q  <= inp_ack_d;
      out_ack_q  <= out_ack_d;
      err_q      <= err_d;
    end
  end

`ifdef IO_TIMEOUT_EN
  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst_b) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign inp_data = inp_data_q;
  assign inp_ack  = inp_ack_q;
  assign out_ack  = out_ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_io_hub_mc.sv
// Directed bench for io_hub_mc: a transaction table plus hand-written
// sequences for back-pressure, arbitration, held requests, reset and stalls.
module tb_io_hub_mc;

  logic        clk;
  logic        rst_b;
  logic        inp_req;
  logic [1:0]  inp_ch;
  logic [15:0] inp_data;
  logic        inp_ack;
  logic        out_req;
  logic [1:0]  out_ch;
  logic [15:0] out_data;
  logic        out_ack;
  logic        err;
  logic [3:0]  dev_in_valid;
  logic [63:0] dev_in_data;
  logic [3:0]  dev_in_ready;
  logic [3:0]  dev_out_valid;
  logic [63:0] dev_out_data;
  logic [3:0]  dev_out_ready;

  int n_vec  = 0;
  int n_miss = 0;

  io_hub_mc #(.DATA_W(16), .N_CH(4), .FIFO_DEPTH(8), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .inp_req       (inp_req),
    .inp_ch        (inp_ch),
    .inp_data      (inp_data),
    .inp_ack       (inp_ack),
    .out_req       (out_req),
    .out_ch        (out_ch),
    .out_data      (out_data),
    .out_ack       (out_ack),
    .err           (err),
    .dev_in_valid  (dev_in_valid),
    .dev_in_data   (dev_in_data),
    .dev_in_ready  (dev_in_ready),
    .dev_out_valid (dev_out_valid),
    .dev_out_data  (dev_out_data),
    .dev_out_ready (dev_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    int          ch;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b1;
    inp_req = 1'b0; inp_ch = '0;
    out_req = 1'b0; out_ch = '0; out_data = '0;
    dev_in_valid = '0; dev_in_data = '0; dev_out_ready = '0;
    tick();
    tick();
    rst_b = 1'b0;
  endtask

  task automatic dev_push(input int c, input logic [15:0] d);
    dev_in_data[c*16 +: 16] = d;
    dev_in_valid[c] = 1'b1;
    tick();
    dev_in_valid[c] = 1'b0;
  endtask

  // Cycle 1 is the cycle the request is raised; cyc=-1 when no ack arrives
  task automatic cpu_read(input int ch, output logic [15:0] d, output logic e, output int cyc);
    inp_ch  = 2'(ch);
    inp_req = 1'b1;
    cyc = 1;
    while (inp_ack !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (inp_ack !== 1'b1) cyc = -1;
    d = inp_data;
    e = err;
    inp_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic cpu_write(input int ch, input logic [15:0] d, output logic e, output int cyc);
    out_ch   = 2'(ch);
    out_data = d;
    out_req  = 1'b1;
    cyc = 1;
    while (out_ack !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (out_ack !== 1'b1) cyc = -1;
    e = err;
    out_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [15:0] d;
    logic        e;
    int          cyc;
    int          acks;
    int          in_cyc, out_cyc;
    logic [15:0] in_d;

    tbl[0] = '{1'b0, 0, 16'h0000, 16'h0101};
    tbl[1] = '{1'b0, 3, 16'h0000, 16'h0301};
    tbl[2] = '{1'b1, 2, 16'hC002, 16'hC002};
    tbl[3] = '{1'b0, 0, 16'h0000, 16'h0102};
    tbl[4] = '{1'b1, 0, 16'hC000, 16'hC000};
    tbl[5] = '{1'b1, 2, 16'hC012, 16'hC002};
    tbl[6] = '{1'b0, 1, 16'h0000, 16'h0201};

    // Reset values, then a single device-to-CPU word
    do_reset();
    check("rst_dev_in_ready", 32'(dev_in_ready), 32'hF);
    check("rst_dev_out_valid", 32'(dev_out_valid), 32'h0);
    check("rst_acks_err", {29'd0, inp_ack, out_ack, err}, 32'h0);
    check("rst_inp_data", 32'(inp_data), 32'h0);
    dev_push(2, 16'h1234);
    cpu_read(2, d, e, cyc);
    check("rd2_latency", 32'(cyc), 32'd3);
    check("rd2_data", 32'(d), 32'h1234);
    check("rd2_err", 32'(e), 32'h0);

    // Transaction table on preloaded RX FIFOs
    dev_push(0, 16'h0101);
    dev_push(0, 16'h0102);
    dev_push(1, 16'h0201);
    dev_push(3, 16'h0301);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) begin
        cpu_write(tbl[i].ch, tbl[i].wdata, e, cyc);
        check($sformatf("tbl%0d_tx_head", i), 32'(dev_out_data[tbl[i].ch*16 +: 16]), 32'(tbl[i].exp));
      end else begin
        cpu_read(tbl[i].ch, d, e, cyc);
        check($sformatf("tbl%0d_rd_data", i), 32'(d), 32'(tbl[i].exp));
      end
      check($sformatf("tbl%0d_latency", i), 32'(cyc), 32'd3);
      check($sformatf("tbl%0d_err", i), 32'(e), 32'h0);
    end

    // Fill TX[1], stall the ninth write, release it with one device pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cpu_write(1, 16'hA000 + 16'(i), e, cyc);
      check($sformatf("fill%0d_latency", i), 32'(cyc), 32'd3);
    end
    check("fill_valid1", 32'(dev_out_valid[1]), 32'h1);
    out_ch = 2'd1; out_data = 16'hA008; out_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_ack) acks++;
    end
    check("full_stall_acks", 32'(acks), 32'd0);
    check("full_head_first", 32'(dev_out_data[31:16]), 32'hA000);
    dev_out_ready[1] = 1'b1;
    tick();
    dev_out_ready[1] = 1'b0;
    acks = 0;
    for (int i = 0; i < 10 && acks == 0; i++) begin
      tick();
      if (out_ack) acks++;
    end
    check("full_release_ack", 32'(acks), 32'd1);
    out_req = 1'b0;
    tick();
    tick();
    check("full_head_next", 32'(dev_out_data[31:16]), 32'hA001);

    // Simultaneous requests: read wins, write follows after release
    do_reset();
    dev_push(0, 16'h0055);
    inp_ch = 2'd0; inp_req = 1'b1;
    out_ch = 2'd3; out_data = 16'hBEEF; out_req = 1'b1;
    in_cyc = -1; out_cyc = -1; in_d = '0;
    for (int c = 1; c <= 30; c++) begin
      if (inp_ack) begin in_cyc = c; in_d = inp_data; inp_req = 1'b0; end
      if (out_ack) begin out_cyc = c; out_req = 1'b0; end
      tick();
    end
    check("both_in_cyc", 32'(in_cyc), 32'd3);
    check("both_out_cyc", 32'(out_cyc), 32'd7);
    check("both_in_data", 32'(in_d), 32'h0055);
    check("both_tx3_head", 32'(dev_out_data[63:48]), 32'hBEEF);
    check("both_tx3_valid", 32'(dev_out_valid[3]), 32'h1);

    // Held read request is serviced once
    do_reset();
    dev_push(0, 16'h0AAA);
    dev_push(0, 16'h0BBB);
    inp_ch = 2'd0; inp_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 10 && acks == 0; i++) begin
      tick();
      if (inp_ack) acks++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inp_ack) acks++;
    end
    check("held_ack_count", 32'(acks), 32'd1);
    inp_req = 1'b0;
    tick();
    tick();
    cpu_read(0, d, e, cyc);
    check("held_second_data", 32'(d), 32'h0BBB);
    check("held_second_latency", 32'(cyc), 32'd3);

    // Reset while stalled in RD_WAIT aborts and empties the FIFOs
    do_reset();
    dev_push(0, 16'h0E01);
    dev_push(0, 16'h0E02);
    dev_push(0, 16'h0E03);
    inp_ch = 2'd2; inp_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (inp_ack) acks++;
    end
    rst_b = 1'b1;
    inp_req = 1'b0;
    tick();
    if (inp_ack) acks++;
    rst_b = 1'b0;
    check("rstmid_no_ack", 32'(acks), 32'd0);
    cpu_write(0, 16'h5A5A, e, cyc);
    check("rstmid_idle_latency", 32'(cyc), 32'd3);
    for (int i = 0; i < 5; i++) dev_push(0, 16'h0F00 + 16'(i));
    check("rstmid_cnt_cleared", 32'(dev_in_ready[0]), 32'h1);
    for (int i = 5; i < 8; i++) dev_push(0, 16'h0F00 + 16'(i));
    check("rstmid_full_after8", 32'(dev_in_ready[0]), 32'h0);
    cpu_read(0, d, e, cyc);
    check("rstmid_first_new", 32'(d), 32'h0F00);

    // Read of an empty channel
    do_reset();
`ifdef IO_TIMEOUT_EN
    cpu_read(3, d, e, cyc);
    check("tmo_latency", 32'(cyc), 32'd18);
    check("tmo_err", 32'(e), 32'h1);
    check("tmo_data", 32'(d), 32'h0);
    check("tmo_err_clear", 32'(err), 32'h0);
`else
    inp_ch = 2'd3; inp_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (inp_ack) acks++;
    end
    check("stall_no_ack_1000", 32'(acks), 32'd0);
    inp_req = 1'b0;
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_hub_mc.md
Name: io_hub_mc

Overview:
- Multi-channel successor to the single-channel input/output units.
- Bridges the CPU's inp_req/inp_ack and out_req/out_ack handshakes to N_CH device channels.
- Each channel has its own RX FIFO (device to CPU) and TX FIFO (CPU to device).
- Sits beside the CPU and memory in the SoC and replaces the separate input and output units; the CPU selects a channel per transfer.

Parameters:
- DATA_W, 16, data word width on the CPU and device sides.
- N_CH, 4, number of channels; range 1..16; CH_W = max(1, clog2(N_CH)).
- FIFO_DEPTH, 8, entries per FIFO; power of two, at least 2.
- TIMEOUT, 255, stall limit in cycles; used only with IO_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst_b  input  1  reset; the block has one clock and reset is synchronous and active-high (rst_b=1 resets)
- inp_req  input  1  CPU read request, held high until inp_ack is seen
- inp_ch  input  CH_W  channel for the read, sampled at request acceptance
- inp_data  output  DATA_W  read data, valid while inp_ack=1
- inp_ack  output  1  one-cycle read acknowledge
- out_req  input  1  CPU write request, held high until out_ack is seen
- out_ch  input  CH_W  channel for the write, sampled at acceptance
- out_data  input  DATA_W  write data, sampled at acceptance
- out_ack  output  1  one-cycle write acknowledge
- err  output  1  timeout flag, qualified by inp_ack or out_ack
- dev_in_valid  input  N_CH  per-channel device push strobe
- dev_in_data  input  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- dev_in_ready  output  N_CH  equals not-full of RX FIFO c
- dev_out_valid  output  N_CH  equals not-empty of TX FIFO c
- dev_out_data  output  N_CH*DATA_W  head of TX FIFO c
- dev_out_ready  input  N_CH  device pop strobe

Behaviour:
- Reset (rst_b=1 at a clk edge):
  - all FIFO pointers and counts cleared
  - inp_ack=0, out_ack=0, err=0, inp_data=0
  - dev_in_ready all 1, dev_out_valid all 0
  - FSM goes to IDLE
  - reset mid-transfer aborts the transfer with no ack, and all FIFO contents are discarded
- FIFOs:
  - push when valid&ready; pop when valid&ready
  - full = count==FIFO_DEPTH; ready ignores a same-cycle pop, so a full FIFO never accepts a push
  - simultaneous push and pop on a non-empty, non-full FIFO keeps count unchanged
  - pointers wrap modulo FIFO_DEPTH
  - a device push is visible to the CPU side on the next cycle
- FSM states:
  - IDLE: if inp_req, latch inp_ch and go to RD_WAIT; else if out_req, latch out_ch and out_data and go to WR_WAIT. Input has priority when both requests are high; the write is taken after the read completes.
  - RD_WAIT: when RX[ch] is non-empty, pop it and register the head into inp_data, then go to RD_ACK. Otherwise stall.
  - RD_ACK: inp_ack=1 for exactly one cycle; inp_data is held until the next read ack. Go to RELEASE.
  - WR_WAIT: when TX[ch] is not full, push the latched word and go to WR_ACK. Otherwise stall.
  - WR_ACK: out_ack=1 for exactly one cycle; go to RELEASE.
  - RELEASE: wait until the request just serviced is low, then go to IDLE. This prevents double service of a held req.
- Latency, non-stalled: request to ack is 3 cycles (IDLE, xx_WAIT, xx_ACK).
- Channel index at or above N_CH: treated as an always-empty, always-full channel, so the transfer stalls, or times out under IO_TIMEOUT_EN.
- A CPU write and a device pop on the same TX FIFO in the same cycle are both honoured.
- A CPU read pop and a device push on the same RX FIFO in the same cycle are both honoured.

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- Defined:
  - A stall counter runs in RD_WAIT and WR_WAIT and is cleared on entry to either state.
  - When the count reaches TIMEOUT, the FSM goes to the ack state with err=1.
  - A read timeout returns inp_data=0 and pops nothing.
  - A write timeout pushes nothing.
  - err is high only during that ack cycle.
- Undefined: no counter is built, err is tied to 0, and stalls last indefinitely.

Test Plan:
- Reset, then device pushes 0x1234 on channel 2; CPU reads channel 2 -> dev_in_ready=4'b1111 after reset; inp_ack pulses 3 cycles after inp_req with inp_data=0x1234 and err=0.
- CPU writes 0xA000..0xA007 to channel 1 with dev_out_ready=0 -> 8 acks and dev_out_valid[1]=1; a 9th write stalls with no out_ack; raising dev_out_ready[1] emits 0xA000 first, then the stalled write acks.
- inp_req and out_req rise together (read channel 0 holding 0x0055, write 0xBEEF to channel 3) -> inp_ack first, then out_ack; TX[3] head is 0xBEEF.
- inp_req held high for 10 cycles after its ack -> exactly one inp_ack and one RX pop.
- Reset asserted in RD_WAIT with 3 words in RX[0] -> no ack, count=0, FSM in IDLE the cycle after reset deasserts.
- Under IO_TIMEOUT_EN with TIMEOUT=16, read an empty channel 3 -> inp_ack at stall cycle 16 with err=1 and inp_data=0; with the macro undefined, no ack within 1000 cycles.
